ula_arbiter: RTL and testbench

Shares the single 32-bit ULA between two requesters (e.g. execute stage and address-generation unit) using per-requester valid/ready handshakes. The block:

- arbitrates between pending requests;
- registers the winner's operands and operation code and drives them onto the ULA;
- captures the ULA result and zero flag;
- holds the response until the owning requester acknowledges it.

It sits between the requesters and the combinational ULA, and is the only driver of the ULA's inputs.

---
 rtl/ula_arbiter_if.sv | 45 ++++
 rtl/ula_arbiter.sv | 129 ++++++++++++
 tb/tb_ula_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_arbiter_if.sv
// rtl/ula_arbiter_if.sv - requester, response and ULA-side signals of ula_arbiter
interface ula_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [3:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, alu_ctrl, alu_a, alu_b, busy, op_count
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, alu_ctrl, alu_a, alu_b, busy, op_count
  );
endinterface

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - shares one combinational ULA between two requesters
// Define ULA_ARB_RR_EN for round-robin tie-breaking; fixed priority (requester 0) otherwise.
module ula_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  ula_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              grant1;
  logic              any_req;
  logic              req0_ready_c;
  logic              req1_ready_c;
  logic              owner_ack;

  always_comb begin
    any_req = bus.req0_valid | bus.req1_valid;
`ifdef ULA_ARB_RR_EN
    if (bus.req0_valid && bus.req1_valid) begin
      grant1 = ~last_owner_q;
    end else begin
      grant1 = bus.req1_valid;
    end
`else
    grant1 = bus.req1_valid & ~bus.req0_valid;
`endif
  end

  assign owner_ack = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    count_d      = count_q;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          req0_ready_c = ~grant1;
          req1_ready_c = grant1;
          op_d         = grant1 ? bus.req1_op : bus.req0_op;
          a_d          = grant1 ? bus.req1_a  : bus.req0_a;
          b_d          = grant1 ? bus.req1_b  : bus.req0_b;
          owner_d      = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = bus.alu_result;
        zero_d   = bus.alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_ack) begin
          count_d      = count_q + 1'b1;
          last_owner_d = owner_q;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      count_q      <= count_d;
    end
  end

  // Ready is combinational from IDLE, so hold it low while reset is asserted.
  assign bus.req0_ready = req0_ready_c & rst_n;
  assign bus.req1_ready = req1_ready_c & rst_n;
  assign bus.rsp0_valid = (state_q == RESP) & ~owner_q;
  assign bus.rsp1_valid = (state_q == RESP) & owner_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.alu_ctrl   = op_q;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.op_count   = count_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - scoreboard bench for ula_arbiter with a behavioural ULA
module tb_ula_arbiter;

  typedef struct {
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   compared;
  int   mismatched;

  exp_t q0[$];
  exp_t q1[$];
  int   grant_id[$];
  int   grant_t[$];

  ula_arbiter_if #(.DATA_W(32), .CNT_W(4)) bus ();

  ula_arbiter #(.DATA_W(32), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Behavioural ULA: codes 9-15 return zero.
  always_comb begin
    case (bus.alu_ctrl)
      4'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
      4'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
      4'd4:    bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'd5:    bus.alu_result = ~(bus.alu_a | bus.alu_b);
      4'd6:    bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      4'd7:    bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      4'd8:    bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      default: bus.alu_result = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor and grant logger.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.rsp0_valid && bus.rsp0_ready) begin
          if (q0.size() == 0) begin
            check("rsp0_unexpected", 32'd1, 32'd0);
          end else begin
            e = q0.pop_front();
            check("rsp0_result", bus.rsp_result, e.res);
            check("rsp0_zero", {31'd0, bus.rsp_zero}, {31'd0, e.z});
          end
        end
        if (bus.rsp1_valid && bus.rsp1_ready) begin
          if (q1.size() == 0) begin
            check("rsp1_unexpected", 32'd1, 32'd0);
          end else begin
            e = q1.pop_front();
            check("rsp1_result", bus.rsp_result, e.res);
            check("rsp1_zero", {31'd0, bus.rsp_zero}, {31'd0, e.z});
          end
        end
        if (bus.req0_ready || bus.req1_ready) begin
          check("single_grant", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
          grant_id.push_back(bus.req1_ready ? 1 : 0);
          grant_t.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Entered and left at posedge+1; valid drops after the accept cycle.
  task automatic do_req(input int n, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input logic z,
                        input bit push);
    exp_t e;
    bit   got;
    e.res = res;
    e.z   = z;
    got   = 0;
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if ((n == 0 && bus.req0_ready) || (n == 1 && bus.req1_ready)) begin
        got = 1;
        if (push) begin
          if (n == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
    if (!got) check("req_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (!bus.busy) done = 1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_op = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", {31'd0, bus.req0_ready}, 32'd0);
    check("rst_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    check("rst_rsp_result", bus.rsp_result, 32'd0);
    check("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
    check("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_op_count", {28'd0, bus.op_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op: 5 + 7 with exact latency
    q0.push_back('{res: 32'd12, z: 1'b0});
    bus.req0_valid = 1'b1; bus.req0_op = 4'd0; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    @(negedge clk);
    check("single_ready_T", {31'd0, bus.req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check("single_rsp_T1", {31'd0, bus.rsp0_valid}, 32'd0);
    check("single_alu_a", bus.alu_a, 32'd5);
    check("single_alu_b", bus.alu_b, 32'd7);
    @(negedge clk);
    check("single_rsp_T2", {31'd0, bus.rsp0_valid}, 32'd1);
    @(negedge clk);
    check("single_busy_T3", {31'd0, bus.busy}, 32'd0);
    check("single_count_T3", {28'd0, bus.op_count}, 32'd1);
    @(posedge clk);
    #1;

    // Subtract to zero on requester 1
    do_req(1, 4'd1, 32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 1'b1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sub_rsp0_quiet", {31'd0, bus.rsp0_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset mid-EXEC discards the operation
    do_req(0, 4'd0, 32'd10, 32'd20, 32'd30, 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_alu_a", bus.alu_a, 32'd0);
    check("midrst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    check("midrst_rsp_result", bus.rsp_result, 32'd0);
    check("midrst_op_count", {28'd0, bus.op_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Continuous contention
    grant_id.delete();
    grant_t.delete();
    fork
      begin
        do_req(0, 4'd0, 32'd100, 32'd23, 32'd123, 1'b0, 1);
        do_req(0, 4'd2, 32'hFF00, 32'h0FF0, 32'h0F00, 1'b0, 1);
        do_req(0, 4'd3, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1);
        do_req(0, 4'd4, 32'hAA, 32'hAA, 32'd0, 1'b1, 1);
      end
      begin
        do_req(1, 4'd1, 32'd50, 32'd8, 32'd42, 1'b0, 1);
        do_req(1, 4'd7, 32'd1, 32'd4, 32'd16, 1'b0, 1);
        do_req(1, 4'd8, 32'h80, 32'd3, 32'h10, 1'b0, 1);
        do_req(1, 4'd6, 32'd3, 32'd9, 32'd1, 1'b0, 1);
      end
    join
    wait_idle();
    check("contend_grants", grant_id.size(), 32'd8);
    for (int i = 0; i < 8 && i < grant_id.size(); i++) begin
`ifdef ULA_ARB_RR_EN
      check("contend_owner", grant_id[i], i % 2);
`else
      check("contend_owner", grant_id[i], (i >= 4) ? 1 : 0);
`endif
      if (i > 0) check("contend_spacing", grant_t[i] - grant_t[i-1], 32'd3);
    end

    // Backpressure on requester 0 while requester 1 waits
    bus.rsp0_ready = 1'b0;
    fork
      do_req(0, 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1);
      do_req(1, 4'd2, 32'hF0, 32'h3C, 32'h30, 1'b0, 1);
      begin
        bit seen;
        seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
          @(negedge clk);
          if (bus.rsp0_valid) seen = 1;
        end
        if (!seen) check("bp_rsp_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_result_hold", bus.rsp_result, 32'd3);
          check("bp_req1_blocked", {31'd0, bus.req1_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_req1_next", {31'd0, bus.req1_ready}, 32'd1);
      end
    join
    wait_idle();

    // Illegal op and counter wrap with CNT_W = 4
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 0) do_req(0, 4'd15, 32'd3, 32'd4, 32'd0, 1'b1, 1);
      else        do_req(0, 4'd0, i, 32'd1, i + 1, 1'b0, 1);
      wait_idle();
      if (i == 14) check("wrap_count_15", {28'd0, bus.op_count}, 32'd15);
      if (i == 15) check("wrap_count_0", {28'd0, bus.op_count}, 32'd0);
    end

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    t0 = compared;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", t0, mismatched);
    $finish;
  end

endmodule
